seg7_bus_reader: RTL and testbench
==================================

# seg7_bus_reader

Captures a multiplexed, active-low 7-segment display bus (segment lines plus one-hot active-low digit enables) and recovers the BCD value shown on each digit. This is the receive end of the display path: it takes the segment patterns our digit decoders drive and turns them back into nibbles. It feeds self-check logic and the board-level display monitor. It filters glitches with a per-sample stability counter and delivers one complete frame at a time over a valid/ready handshake.

## Interface
- `DIGITS`, default 4: number of multiplexed digits; sets the widths of `an_in` and the outputs.
- `STABLE_CNT`, default 4: number of consecutive identical qualifying samples needed to accept a digit pattern; legal range 2..255.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sample_en` in 1: sample strobe; the bus inputs are examined only in cycles where it is 1.
- `seg_in` in 7: segment lines g..a, bit 6 = g, active-low.
- `an_in` in DIGITS: digit enables, active-low, one-hot; bit i selects digit i.
- `digits_out` out 4*DIGITS: recovered values; digit i occupies bits [4i+3:4i].
- `digit_err` out DIGITS: bit i = 1 when digit i's captured pattern is not a legal code.
- `frame_valid` out 1: a complete frame is held in `digits_out`/`digit_err`.
- `frame_ready` in 1: consumer accepts the frame.
- `overflow` out 1: sticky; at least one completed frame was dropped.

## Operation
- Decode map (active-low pattern → value):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 18→9.
  - 3F (dash) → 4'hE, err=0.
  - Any other pattern, including 7F blank → 4'hF, err=1.
- Qualifying sample: `sample_en`=1 and `~an_in` has exactly one bit set.
- Non-qualifying sample when `sample_en`=1 (zero or multiple enables low): the stability counter clears and the last-sample register is invalidated.
- Stability tracking:
  - The block registers {an_in, seg_in} of the last qualifying sample.
  - If the new sample is equal, the counter increments, saturating at STABLE_CNT.
  - Otherwise the counter loads 1.
- Commit: on the sample where the counter becomes exactly STABLE_CNT, the decoded value and err are written to shadow slot i and `seen[i]` is set.
  - A held pattern commits only once; it does not commit again until the sample changes.
  - Re-committing a digit before the frame completes overwrites its slot.
- Frame complete: when `seen` would become all ones, the shadow contents plus the digit being committed load into the output registers, and `seen` clears.
  - If `frame_valid`=0, or `frame_ready`=1 in the same cycle: the outputs load and `frame_valid`=1.
  - If `frame_valid`=1 and `frame_ready`=0: the outputs are unchanged, the frame is dropped, and `overflow` is set.
- Handshake: `frame_valid` and `frame_ready` both 1 with no new frame completing → `frame_valid` clears next edge. Outputs stay stable while `frame_valid`=1.
- Reset mid-frame: the partial frame is discarded. There is no recovery; capture restarts from scratch.

## Timing
- Reset values:
  - `digits_out`=0, `digit_err`=0, `frame_valid`=0, `overflow`=0.
  - Internal: counter=0, `seen`=0, shadow=0, last-sample register invalid.
- Latency: the output registers update on the same edge that captures the final stable sample of the last missing digit. `frame_valid` is high from the following cycle.
- Minimum capture: STABLE_CNT qualifying samples per digit, i.e. DIGITS×STABLE_CNT samples per frame.
- `frame_ready` is ignored while `frame_valid`=0.
- `overflow` clears only on reset.

## Configuration
- `SEG7_DP_EN` defined:
  - Adds input `seg_dp` (1, active-low) and output `dp_out` (DIGITS, reset 0, active-high "point lit").
  - dp takes part in the stability compare and is committed and framed together with its digit.
- `SEG7_DP_EN` undefined: neither port exists; the compare is 7 bits wide.

## Structure
- Package `seg7_pkg`:
  - Pattern constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK (7-bit, active-low).
  - Value constants VAL_DASH=4'hE, VAL_ERR=4'hF.
  - This package is shared with the segment decoders.
- Sub-module `seg7_pattern_decode`: combinational, 7-bit pattern in → 4-bit value + err out; one instance.
- Top-level RTL holds the stability counter, shadow bank, frame registers and handshake.

## Test plan
- Reset then DIGITS=4, STABLE_CNT=4; drive 4 samples each of an=1110/seg=79, an=1101/seg=24, an=1011/seg=30, an=0111/seg=19 → `digits_out`=16'h4321, `digit_err`=0, `frame_valid`=1.
- 3 identical samples of a digit followed by a glitch sample → no commit. Then 4 samples of seg=12 → digit value 5.
- Pattern 3F on digit 0 → nibble E, err 0. Pattern 7F → nibble F, err 1. Pattern 55 → nibble F, err 1.
- Complete a frame with `frame_ready`=0, then complete a second frame → first frame retained, `overflow`=1. Assert `frame_ready` in the same cycle as a third frame completes → third frame loads, `frame_valid` stays 1.
- an=1100 or an=1111 samples interleaved → counter clears and no commits occur. Assert `rst` with 3 of 4 digits seen → all outputs 0, and a subsequent full frame is required before `frame_valid`.
- With `SEG7_DP_EN`: a digit held with `seg_dp` toggling → no commit. With `seg_dp`=0 stable → `dp_out[i]`=1.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment pattern and value constants
// Patterns are active-low, bit order g..a (bit 6 = g). The segment decoders use the same constants.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] VAL_DASH  = 4'hE;
  localparam logic [3:0] VAL_ERR   = 4'hF;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - active-low segment pattern to BCD value
// Ports: pattern (7, g..a active-low) in; value (4) out; err (1) out, set for any non-digit, non-dash code.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       err
);

  always_comb begin
    value = VAL_ERR;
    err   = 1'b0;
    case (pattern)
      SEG_0:    value = 4'd0;
      SEG_1:    value = 4'd1;
      SEG_2:    value = 4'd2;
      SEG_3:    value = 4'd3;
      SEG_4:    value = 4'd4;
      SEG_5:    value = 4'd5;
      SEG_6:    value = 4'd6;
      SEG_7:    value = 4'd7;
      SEG_8:    value = 4'd8;
      SEG_9:    value = 4'd9;
      SEG_DASH: value = VAL_DASH;
      default: begin
        value = VAL_ERR;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_bus_reader.sv
// rtl/seg7_bus_reader.sv - recovers BCD digits from a multiplexed active-low 7-segment bus
// Ports: clk, rst (async, active-high); sample_en strobe; seg_in (7, g..a active-low);
//   an_in (DIGITS, one-hot active-low); digits_out (4*DIGITS); digit_err (DIGITS);
//   frame_valid / frame_ready handshake; overflow (sticky dropped-frame flag).
// Option SEG7_DP_EN: adds seg_dp in (active-low) and dp_out (DIGITS, active-high point lit).
module seg7_bus_reader
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_en,
  input  logic [6:0]            seg_in,
`ifdef SEG7_DP_EN
  input  logic                  seg_dp,
  output logic [DIGITS-1:0]     dp_out,
`endif
  input  logic [DIGITS-1:0]     an_in,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overflow
);

`ifdef SEG7_DP_EN
  localparam int PW = 8;
  logic [PW-1:0] pattern;
  assign pattern = {seg_dp, seg_in};
`else
  localparam int PW = 7;
  logic [PW-1:0] pattern;
  assign pattern = seg_in;
`endif

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CNT);

  logic [DIGITS-1:0]      sel;
  logic                   qual;
  logic [DIGITS+PW-1:0]   sample_now;
  logic [DIGITS+PW-1:0]   last_sample;
  logic                   last_vld;
  logic [7:0]             cnt;
  logic                   same;
  logic                   commit;
  logic [3:0]             dec_val;
  logic                   dec_err;
  logic [4*DIGITS-1:0]    shadow_val;
  logic [DIGITS-1:0]      shadow_err;
  logic [4*DIGITS-1:0]    next_val;
  logic [DIGITS-1:0]      next_err;
  logic [DIGITS-1:0]      seen;
  logic [DIGITS-1:0]      seen_next;
  logic                   frame_done;
  logic                   frame_load;

  assign sel        = ~an_in;
  assign qual       = sample_en && $onehot(sel);
  assign sample_now = {an_in, pattern};
  assign same       = last_vld && (sample_now == last_sample);
  // Commit only on the transition into CNT_MAX, so a held pattern commits once.
  assign commit     = qual && same && (cnt == CNT_MAX - 8'd1);
  assign seen_next  = seen | sel;
  assign frame_done = commit && (&seen_next);
  assign frame_load = frame_done && (!frame_valid || frame_ready);

  seg7_pattern_decode u_decode (
    .pattern (seg_in),
    .value   (dec_val),
    .err     (dec_err)
  );

  // Shadow bank with the digit being committed merged in; sel is one-hot whenever commit is high.
  always_comb begin
    next_val = shadow_val;
    next_err = shadow_err;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel[i]) begin
        next_val[4*i +: 4] = dec_val;
        next_err[i]        = dec_err;
      end
    end
  end

`ifdef SEG7_DP_EN
  logic [DIGITS-1:0] shadow_dp;
  logic [DIGITS-1:0] next_dp;

  always_comb begin
    next_dp = shadow_dp;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel[i]) next_dp[i] = ~seg_dp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_dp <= '0;
      dp_out    <= '0;
    end else begin
      if (commit)     shadow_dp <= next_dp;
      if (frame_load) dp_out    <= next_dp;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_sample <= '0;
      last_vld    <= 1'b0;
      cnt         <= 8'd0;
      shadow_val  <= '0;
      shadow_err  <= '0;
      seen        <= '0;
      digits_out  <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (sample_en) begin
        if (qual) begin
          last_sample <= sample_now;
          last_vld    <= 1'b1;
          if (!same)               cnt <= 8'd1;
          else if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
        end else begin
          cnt      <= 8'd0;
          last_vld <= 1'b0;
        end
      end

      if (commit) begin
        shadow_val <= next_val;
        shadow_err <= next_err;
        seen       <= frame_done ? '0 : seen_next;
      end

      if (frame_load) begin
        digits_out  <= next_val;
        digit_err   <= next_err;
        frame_valid <= 1'b1;
      end else if (frame_done) begin
        overflow <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_bus_reader.sv
// tb/tb_seg7_bus_reader.sv - directed self-checking bench for seg7_bus_reader
module tb_seg7_bus_reader;

  localparam int DIGITS = 4;

  logic                 clk;
  logic                 rst;
  logic                 sample_en;
  logic [6:0]           seg_in;
  logic [DIGITS-1:0]    an_in;
  logic [4*DIGITS-1:0]  digits_out;
  logic [DIGITS-1:0]    digit_err;
  logic                 frame_valid;
  logic                 frame_ready;
  logic                 overflow;
`ifdef SEG7_DP_EN
  logic                 seg_dp;
  logic [DIGITS-1:0]    dp_out;
`endif

  int errors = 0;
  int checks = 0;

  seg7_bus_reader #(.DIGITS(DIGITS), .STABLE_CNT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (sample_en),
    .seg_in      (seg_in),
`ifdef SEG7_DP_EN
    .seg_dp      (seg_dp),
    .dp_out      (dp_out),
`endif
    .an_in       (an_in),
    .digits_out  (digits_out),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // n qualifying samples of one digit, then one idle cycle with sample_en low
  task automatic put(input logic [3:0] an, input logic [6:0] seg, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      an_in     = an;
      seg_in    = seg;
      sample_en = 1'b1;
    end
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [15:0] val, input logic [3:0] err,
                             input logic fv, input logic ovf);
    check({tag, "_digits"}, 32'(digits_out), 32'(val));
    check({tag, "_err"},    32'(digit_err),  32'(err));
    check({tag, "_valid"},  32'(frame_valid), 32'(fv));
    check({tag, "_ovf"},    32'(overflow),   32'(ovf));
  endtask

  initial begin
    rst         = 1'b1;
    sample_en   = 1'b0;
    an_in       = 4'b1111;
    seg_in      = 7'h7F;
    frame_ready = 1'b0;
`ifdef SEG7_DP_EN
    seg_dp      = 1'b1;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_frame("reset", 16'h0000, 4'b0000, 1'b0, 1'b0);

    // Frame 1: 1,2,3,4 on digits 0..3
    put(4'b1110, 7'h79, 4);
    put(4'b1101, 7'h24, 4);
    put(4'b1011, 7'h30, 4);
    put(4'b0111, 7'h19, 3);
    check("latency_pre", 32'(frame_valid), 32'd0);
    put(4'b0111, 7'h19, 1);
    check_frame("frame1", 16'h4321, 4'b0000, 1'b1, 1'b0);
`ifdef SEG7_DP_EN
    check("frame1_dp", 32'(dp_out), 32'd0);
`endif
    @(negedge clk);
    check("frame1_hold", 32'(frame_valid), 32'd1);
    consume();
    check("frame1_taken", 32'(frame_valid), 32'd0);

    // Frame 2: dash, blank, 55, glitched digit 0 then 5
    put(4'b1101, 7'h3F, 4);
    put(4'b1011, 7'h7F, 4);
    put(4'b0111, 7'h55, 4);
    put(4'b1110, 7'h79, 3);
    put(4'b1110, 7'h7F, 1);
    check("glitch_no_commit", 32'(frame_valid), 32'd0);
    put(4'b1110, 7'h12, 4);
    check_frame("frame2", 16'hFFE5, 4'b1100, 1'b1, 1'b0);
    consume();

    // Overflow: frame A held, frame B dropped, frame C accepted with ready on its last edge
    put(4'b1110, 7'h3F, 8);
    put(4'b1101, 7'h02, 4);
    put(4'b1011, 7'h78, 4);
    put(4'b0111, 7'h00, 4);
    check_frame("frameA", 16'h876E, 4'b0000, 1'b1, 1'b0);
    put(4'b1110, 7'h40, 4);
    put(4'b1101, 7'h18, 4);
    put(4'b1011, 7'h79, 4);
    put(4'b0111, 7'h24, 4);
    check_frame("frameB_drop", 16'h876E, 4'b0000, 1'b1, 1'b1);
    put(4'b1110, 7'h30, 4);
    put(4'b1101, 7'h19, 4);
    put(4'b1011, 7'h12, 4);
    put(4'b0111, 7'h02, 3);
    @(negedge clk);
    an_in       = 4'b0111;
    seg_in      = 7'h02;
    sample_en   = 1'b1;
    frame_ready = 1'b1;
    @(negedge clk);
    sample_en   = 1'b0;
    frame_ready = 1'b0;
    check_frame("frameC", 16'h6543, 4'b0000, 1'b1, 1'b1);
    consume();
    check("frameC_taken", 32'(frame_valid), 32'd0);

    // Illegal enable patterns clear the stability counter
    put(4'b1101, 7'h00, 4);
    put(4'b1011, 7'h18, 4);
    put(4'b0111, 7'h40, 4);
    put(4'b1110, 7'h79, 2);
    put(4'b1100, 7'h79, 1);
    put(4'b1110, 7'h79, 2);
    put(4'b1111, 7'h79, 1);
    put(4'b1110, 7'h79, 3);
    check("bad_an_no_commit", 32'(frame_valid), 32'd0);
    put(4'b1110, 7'h79, 1);
    check_frame("frame_bad_an", 16'h0981, 4'b0000, 1'b1, 1'b1);
    consume();

    // Reset with three of four digits seen
    put(4'b1110, 7'h79, 4);
    put(4'b1101, 7'h24, 4);
    put(4'b1011, 7'h30, 4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_frame("midreset", 16'h0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    put(4'b0111, 7'h19, 4);
    check("post_reset_partial", 32'(frame_valid), 32'd0);
    put(4'b1110, 7'h12, 4);
    put(4'b1101, 7'h02, 4);
    put(4'b1011, 7'h78, 4);
    check_frame("post_reset", 16'h4765, 4'b0000, 1'b1, 1'b0);
    consume();

`ifdef SEG7_DP_EN
    put(4'b1101, 7'h24, 4);
    put(4'b1011, 7'h30, 4);
    put(4'b0111, 7'h19, 4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      an_in     = 4'b1110;
      seg_in    = 7'h79;
      seg_dp    = k[0];
      sample_en = 1'b1;
    end
    @(negedge clk);
    sample_en = 1'b0;
    check("dp_toggle_no_commit", 32'(frame_valid), 32'd0);
    seg_dp = 1'b0;
    put(4'b1110, 7'h79, 4);
    check("dp_frame_valid", 32'(frame_valid), 32'd1);
    check("dp_out", 32'(dp_out), 32'd1);
    check("dp_digits", 32'(digits_out), 32'h4321);
    seg_dp = 1'b1;
    consume();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
